// File: rtl/perf_counter_bank.sv
// Bank of CNT_COUNT event counters with per-channel inhibit, sticky overflow
// flags and split-half CSR access with a coherent high-half snapshot.
module perf_counter_bank #(
    parameter int XLEN      = 32,
    parameter int CNT_LEN   = 64,
    parameter int CNT_COUNT = 5,
    parameter int CNT_INC   = 1,
    parameter int SEL_W     = (CNT_COUNT > 1) ? $clog2(CNT_COUNT) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT_COUNT-1:0] inc_i,
    input  logic [CNT_COUNT-1:0] inhibit_i,
    input  logic                 clear_i,
    input  logic                 rd_en_i,
    input  logic [SEL_W-1:0]     rd_sel_i,
    input  logic                 rd_hi_i,
    output logic [XLEN-1:0]      rd_data_o,
    output logic                 rd_valid_o,
    input  logic                 wr_en_i,
    input  logic [SEL_W-1:0]     wr_sel_i,
    input  logic                 wr_hi_i,
    input  logic [XLEN-1:0]      wr_data_i,
    output logic [CNT_COUNT-1:0] ovf_o,
    input  logic                 ovf_clr_i
);

    localparam bit                 HAS_HI  = (CNT_LEN > XLEN);
    localparam logic [CNT_LEN-1:0] LO_MASK = CNT_LEN'({XLEN{1'b1}});
    localparam logic [CNT_LEN-1:0] INC     = CNT_LEN'(CNT_INC);

    logic [CNT_LEN-1:0]   cnt_q [CNT_COUNT];
    logic [CNT_LEN-1:0]   cnt_d [CNT_COUNT];
    logic [CNT_COUNT-1:0] ovf_q, ovf_d;
    logic [XLEN-1:0]      rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [XLEN-1:0]      snap_q, snap_d;
    logic                 snap_valid_q, snap_valid_d;
    logic [SEL_W-1:0]     snap_sel_q, snap_sel_d;

    logic                 rd_hit;
    logic [CNT_LEN-1:0]   rd_word;
    logic [CNT_LEN-1:0]   wr_word;
    logic                 wr_hit;
    logic                 inc_ok;

    // NOTE: every variable assigned in this block gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        cnt_d        = cnt_q;
        ovf_d        = ovf_q & ~{CNT_COUNT{ovf_clr_i}};
        rd_valid_d   = rd_en_i;
        rd_data_d    = rd_data_q;
        snap_d       = snap_q;
        snap_valid_d = snap_valid_q;
        snap_sel_d   = snap_sel_q;
        rd_hit       = 1'b0;
        rd_word      = '0;
        wr_word      = CNT_LEN'(wr_data_i);
        wr_hit       = 1'b0;
        inc_ok       = 1'b0;

        for (int i = 0; i < CNT_COUNT; i++) begin
            if (rd_sel_i == SEL_W'(i)) begin
                rd_hit  = 1'b1;
                rd_word = cnt_q[i];
            end
        end

        // Reads see pre-update contents; out-of-range selects return zero.
        if (rd_en_i) begin
            rd_data_d = '0;
            if (rd_hit) begin
                if (!rd_hi_i) begin
                    rd_data_d = rd_word[XLEN-1:0];
                    if (HAS_HI) begin
                        snap_d       = XLEN'(rd_word >> XLEN);
                        snap_valid_d = 1'b1;
                        snap_sel_d   = rd_sel_i;
                    end
                end else if (HAS_HI) begin
                    if (snap_valid_q && (snap_sel_q == rd_sel_i)) begin
                        rd_data_d    = snap_q;
                        snap_valid_d = 1'b0;
                    end else begin
                        rd_data_d = XLEN'(rd_word >> XLEN);
                    end
                end
            end
        end

        for (int i = 0; i < CNT_COUNT; i++) begin
            wr_hit = wr_en_i && (wr_sel_i == SEL_W'(i)) && (!wr_hi_i || HAS_HI);
            inc_ok = inc_i[i] && !inhibit_i[i];
            if (wr_hit) begin
                cnt_d[i] = wr_hi_i ? ((cnt_q[i] & LO_MASK) | (wr_word << XLEN))
                                   : ((cnt_q[i] & ~LO_MASK) | wr_word);
                if (snap_sel_d == SEL_W'(i)) begin
                    snap_valid_d = 1'b0;
                end
            end else if (inc_ok) begin
                cnt_d[i] = cnt_q[i] + INC;
                // A sum smaller than the old value means the add carried out.
                if (cnt_d[i] < cnt_q[i]) begin
                    ovf_d[i] = 1'b1;
                end
            end
        end

        if (clear_i) begin
            for (int i = 0; i < CNT_COUNT; i++) begin
                cnt_d[i] = '0;
            end
            ovf_d        = '0;
            snap_d       = '0;
            snap_valid_d = 1'b0;
            snap_sel_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the counter array is plain flops, not RAM, so it can and must take the async reset.
            for (int i = 0; i < CNT_COUNT; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q        <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
            snap_sel_q   <= '0;
        end else begin
            for (int i = 0; i < CNT_COUNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q        <= ovf_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
            snap_sel_q   <= snap_sel_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank at its default configuration
// (XLEN=32, CNT_LEN=64, five channels, increment of one).
module tb_perf_counter_bank;

    localparam int XLEN  = 32;
    localparam int CNT_N = 5;
    localparam int SEL_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CNT_N-1:0]  inc_i;
    logic [CNT_N-1:0]  inhibit_i;
    logic              clear_i;
    logic              rd_en_i;
    logic [SEL_W-1:0]  rd_sel_i;
    logic              rd_hi_i;
    logic [XLEN-1:0]   rd_data_o;
    logic              rd_valid_o;
    logic              wr_en_i;
    logic [SEL_W-1:0]  wr_sel_i;
    logic              wr_hi_i;
    logic [XLEN-1:0]   wr_data_i;
    logic [CNT_N-1:0]  ovf_o;
    logic              ovf_clr_i;

    int n_checks = 0;
    int n_fail   = 0;

    perf_counter_bank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (inc_i),
        .inhibit_i  (inhibit_i),
        .clear_i    (clear_i),
        .rd_en_i    (rd_en_i),
        .rd_sel_i   (rd_sel_i),
        .rd_hi_i    (rd_hi_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .wr_en_i    (wr_en_i),
        .wr_sel_i   (wr_sel_i),
        .wr_hi_i    (wr_hi_i),
        .wr_data_i  (wr_data_i),
        .ovf_o      (ovf_o),
        .ovf_clr_i  (ovf_clr_i)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [SEL_W-1:0] sel, input logic hi, input logic [XLEN-1:0] data);
        wr_en_i   = 1'b1;
        wr_sel_i  = sel;
        wr_hi_i   = hi;
        wr_data_i = data;
        step();
        wr_en_i   = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [SEL_W-1:0] sel, input logic hi,
                              input logic [XLEN-1:0] exp);
        rd_en_i  = 1'b1;
        rd_sel_i = sel;
        rd_hi_i  = hi;
        step();
        rd_en_i  = 1'b0;
        check(tag, rd_data_o, exp);
        check({tag, "_valid"}, rd_valid_o, 1'b1);
    endtask

    task automatic pulse_inc(input logic [CNT_N-1:0] mask, input int cycles);
        inc_i = mask;
        repeat (cycles) step();
        inc_i = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        inc_i     = '0;
        inhibit_i = '0;
        clear_i   = 1'b0;
        rd_en_i   = 1'b0;
        rd_sel_i  = '0;
        rd_hi_i   = 1'b0;
        wr_en_i   = 1'b0;
        wr_sel_i  = '0;
        wr_hi_i   = 1'b0;
        wr_data_i = '0;
        ovf_clr_i = 1'b0;

        // Reset state
        repeat (2) step();
        check("rst_rd_valid", rd_valid_o, 1'b0);
        check("rst_rd_data", rd_data_o, 32'h0);
        check("rst_ovf", ovf_o, 5'b00000);
        rst_n = 1'b1;
        step();

        // Ten counted events on channel 0, then five inhibited ones
        pulse_inc(5'b00001, 10);
        read_check("ch0_lo_10", 3'd0, 1'b0, 32'd10);
        step();
        check("idle_valid_low", rd_valid_o, 1'b0);
        check("idle_data_hold", rd_data_o, 32'd10);
        read_check("ch0_hi_0", 3'd0, 1'b1, 32'd0);
        inhibit_i = 5'b00001;
        pulse_inc(5'b00001, 5);
        inhibit_i = '0;
        read_check("ch0_inhibit", 3'd0, 1'b0, 32'd10);

        // Wrap of channel 1 sets the sticky flag
        write(3'd1, 1'b0, 32'hFFFF_FFFF);
        write(3'd1, 1'b1, 32'hFFFF_FFFF);
        check("ovf_before_wrap", ovf_o, 5'b00000);
        pulse_inc(5'b00010, 1);
        check("ovf_after_wrap", ovf_o, 5'b00010);
        read_check("ch1_wrap_lo", 3'd1, 1'b0, 32'h0);
        read_check("ch1_wrap_hi", 3'd1, 1'b1, 32'h0);
        check("ovf_sticky", ovf_o, 5'b00010);

        // Second wrap coincides with ovf_clr_i: the set wins
        write(3'd1, 1'b0, 32'hFFFF_FFFF);
        write(3'd1, 1'b1, 32'hFFFF_FFFF);
        ovf_clr_i = 1'b1;
        pulse_inc(5'b00010, 1);
        ovf_clr_i = 1'b0;
        check("ovf_set_beats_clr", ovf_o, 5'b00010);

        // Coherent high-half snapshot on channel 2
        write(3'd2, 1'b0, 32'hFFFF_FFFF);
        read_check("ch2_snap_lo", 3'd2, 1'b0, 32'hFFFF_FFFF);
        pulse_inc(5'b00100, 1);
        read_check("ch2_snap_hi", 3'd2, 1'b1, 32'h0);
        read_check("ch2_live_hi", 3'd2, 1'b1, 32'h1);

        // Write drops the same-cycle increment on channel 3
        inc_i = 5'b01000;
        write(3'd3, 1'b0, 32'h0000_1234);
        inc_i = '0;
        read_check("ch3_wr_vs_inc", 3'd3, 1'b0, 32'h0000_1234);

        // Out-of-range select: read returns zero, write ignored, snapshot untouched
        write(3'd2, 1'b0, 32'hFFFF_FFFF);
        read_check("ch2_resnap_lo", 3'd2, 1'b0, 32'hFFFF_FFFF);
        pulse_inc(5'b00100, 1);
        read_check("oor_read", 3'd7, 1'b0, 32'h0);
        write(3'd7, 1'b0, 32'hDEAD_BEEF);
        write(3'd7, 1'b1, 32'hDEAD_BEEF);
        read_check("ch2_snap_kept", 3'd2, 1'b1, 32'h1);
        read_check("ch2_live_after", 3'd2, 1'b1, 32'h2);
        read_check("ch0_after_oor_wr", 3'd0, 1'b0, 32'd10);
        read_check("ch3_after_oor_wr", 3'd3, 1'b0, 32'h0000_1234);
        read_check("ch4_after_oor_wr", 3'd4, 1'b0, 32'h0);

        // Simultaneous read and write sees the old contents
        wr_en_i   = 1'b1;
        wr_sel_i  = 3'd3;
        wr_hi_i   = 1'b0;
        wr_data_i = 32'h0000_0055;
        read_check("ch3_rd_old", 3'd3, 1'b0, 32'h0000_1234);
        wr_en_i   = 1'b0;
        read_check("ch3_rd_new", 3'd3, 1'b0, 32'h0000_0055);

        // Clear beats write and increment; a same-cycle read sees pre-clear data
        read_check("ch2_pre_clear", 3'd2, 1'b0, 32'h0);
        clear_i   = 1'b1;
        inc_i     = 5'b00001;
        wr_en_i   = 1'b1;
        wr_sel_i  = 3'd0;
        wr_hi_i   = 1'b0;
        wr_data_i = 32'h0000_0099;
        read_check("clr_same_cycle_rd", 3'd0, 1'b0, 32'd10);
        clear_i   = 1'b0;
        inc_i     = '0;
        wr_en_i   = 1'b0;
        check("clr_ovf", ovf_o, 5'b00000);
        read_check("clr_ch2_hi", 3'd2, 1'b1, 32'h0);
        for (int i = 0; i < CNT_N; i++) begin
            read_check($sformatf("clr_ch%0d_lo", i), SEL_W'(i), 1'b0, 32'h0);
        end
        read_check("clr_ch1_hi", 3'd1, 1'b1, 32'h0);

        // Reset asserted while a read result is on the outputs
        pulse_inc(5'b10000, 3);
        read_check("ch4_before_rst", 3'd4, 1'b0, 32'd3);
        rd_en_i = 1'b1;
        step();
        check("midrd_valid_high", rd_valid_o, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("midrd_valid_drop", rd_valid_o, 1'b0);
        check("midrd_data_zero", rd_data_o, 32'h0);
        rd_en_i = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
